// File: rtl/swap_sequencer_if.sv
// Command, status and transfer-controller handshake bundle
// between the control unit, the sequencer and the controller.
interface swap_sequencer_if;
  logic [1:0] cmd;
  logic       slot;
  logic       waitTR;
  logic       std;
  logic       ldd;
  logic       pos;
  logic       busy;
  logic       done;
  logic       err;
  logic       resident;
  logic       resident_valid;

  modport master (
    output cmd, slot, waitTR,
    input  std, ldd, pos,
    input  busy, done, err,
    input  resident, resident_valid
  );

  modport slave (
    input  cmd, slot, waitTR,
    output std, ldd, pos,
    output busy, done, err,
    output resident, resident_valid
  );
endinterface

// File: rtl/swap_sequencer.sv
// Turns one store/load/swap command into spaced std/ldd pulses
// and tracks which secondary slot sits in the primary window.
module swap_sequencer #(
  parameter int ACK_TIMEOUT  = 4,
  parameter int XFER_TIMEOUT = 32,
  parameter int CNT_W        = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  swap_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ST_REQ, ST_HI, ST_LO,
    LD_REQ, LD_HI, LD_LO, FIN
  } state_e;

  localparam logic [CNT_W-1:0] ACK_LAST =
    CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] XFER_LAST =
    CNT_W'(XFER_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WD_MAX = '1;

  state_e           state_q, state_d;
  logic [1:0]       cmd_q, cmd_d;
  logic             slot_q, slot_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             std_q, std_d;
  logic             ldd_q, ldd_d;
  logic             pos_q, pos_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             res_q, res_d;
  logic             resv_q, resv_d;

  logic             accept;
  logic             go_ld;
  logic             go_st;
  logic             timeout;
  logic             load_ok;
  logic [CNT_W-1:0] wd_inc;

  // The controller has no reset, so never start while it is busy.
  assign accept = (state_q == IDLE)
                && (bus.cmd != 2'b00)
                && !bus.waitTR;

  assign go_ld = (bus.cmd == 2'b10)
               || (bus.cmd == 2'b11 && !resv_q);

  assign go_st = resv_q
               && (bus.cmd == 2'b01
                   || (bus.cmd == 2'b11
                       && bus.slot != res_q));

  assign wd_inc = (wd_q == WD_MAX)
                ? wd_q
                : wd_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      slot_q  <= 1'b0;
      wd_q    <= '0;
      std_q   <= 1'b0;
      ldd_q   <= 1'b0;
      pos_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      res_q   <= 1'b0;
      resv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      slot_q  <= slot_d;
      wd_q    <= wd_d;
      std_q   <= std_d;
      ldd_q   <= ldd_d;
      pos_q   <= pos_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      res_q   <= res_d;
      resv_q  <= resv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    slot_d  = slot_q;
    wd_d    = wd_q;
    timeout = 1'b0;
    load_ok = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_d  = bus.cmd;
          slot_d = bus.slot;
          unique case (1'b1)
            go_ld:   state_d = LD_REQ;
            go_st:   state_d = ST_REQ;
            default: state_d = FIN;
          endcase
        end
      end
      ST_REQ: begin
        state_d = ST_HI;
        wd_d    = '0;
      end
      LD_REQ: begin
        state_d = LD_HI;
        wd_d    = '0;
      end
      ST_HI, LD_HI: begin
        if (bus.waitTR) begin
          state_d = (state_q == ST_HI)
                  ? ST_LO : LD_LO;
          wd_d    = '0;
        end else if (wd_q >= ACK_LAST) begin
          state_d = FIN;
          timeout = 1'b1;
        end else begin
          wd_d = wd_inc;
        end
      end
      ST_LO: begin
        if (!bus.waitTR) begin
          state_d = (cmd_q == 2'b11)
                  ? LD_REQ : FIN;
        end else if (wd_q >= XFER_LAST) begin
          state_d = FIN;
          timeout = 1'b1;
        end else begin
          wd_d = wd_inc;
        end
      end
      LD_LO: begin
        if (!bus.waitTR) begin
          state_d = FIN;
          load_ok = 1'b1;
        end else if (wd_q >= XFER_LAST) begin
          state_d = FIN;
          timeout = 1'b1;
        end else begin
          wd_d = wd_inc;
        end
      end
      FIN: state_d = IDLE;
    endcase
  end

  always_comb begin
    std_d  = (state_d == ST_REQ);
    ldd_d  = (state_d == LD_REQ);
    done_d = (state_d == FIN);
    busy_d = accept
           || (state_d != IDLE
               && state_d != FIN);

    pos_d = pos_q;
    if (state_d == LD_REQ) begin
      pos_d = slot_d;
    end else if (accept && go_st) begin
      pos_d = res_q;
    end

    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if (timeout) begin
      err_d = 1'b1;
    end

    res_d  = load_ok ? slot_q : res_q;
    resv_d = resv_q;
    if (load_ok) begin
      resv_d = 1'b1;
    end else if (timeout
                 && (state_q == LD_HI
                     || state_q == LD_LO)) begin
      resv_d = 1'b0;
    end
  end

  assign bus.std            = std_q;
  assign bus.ldd            = ldd_q;
  assign bus.pos            = pos_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.err            = err_q;
  assign bus.resident       = res_q;
  assign bus.resident_valid = resv_q;

endmodule
